// File: rtl/sha_w_sched_ctrl_pkg.sv
// Shared constants and FSM encoding for the SHA-256 message schedule controller.
package sha_w_sched_ctrl_pkg;

    localparam int unsigned WORD_S_DEF = 32;
    localparam int unsigned ROUNDS_DEF = 64;
    localparam int unsigned W_BLKCNT   = 16;
    localparam int unsigned IDX_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sha_w_window.sv
// 16-word sliding message window with the W_t expansion adder.
// win[0] holds the word of the current round, win[k] the word k rounds ahead.
module sha_w_window
    import sha_w_sched_ctrl_pkg::*;
#(
    parameter int unsigned WORD_S = WORD_S_DEF
) (
    input  logic                         clk,
    input  logic                         load,
    input  logic                         shift,
    input  logic [W_BLKCNT*WORD_S-1:0]   block,
    output logic [WORD_S-1:0]            w_next
);

    logic [WORD_S-1:0] win [W_BLKCNT];
    logic [WORD_S-1:0] w_new;

    function automatic logic [WORD_S-1:0] rotr(input logic [WORD_S-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_S - n));
    endfunction

    function automatic logic [WORD_S-1:0] sig0(input logic [WORD_S-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_S-1:0] sig1(input logic [WORD_S-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // New word W[t+16] built only from registered window contents
    always_comb begin
        w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    // Load a fresh block or slide the window by one round
    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned i = 0; i < W_BLKCNT; i++) begin
                win[i] <= block[(W_BLKCNT - i) * WORD_S - 1 -: WORD_S];
            end
        end else if (shift) begin
            for (int unsigned i = 0; i < W_BLKCNT - 1; i++) begin
                win[i] <= win[i + 1];
            end
            win[W_BLKCNT - 1] <= w_new;
        end
    end

    assign w_next = win[1];

endmodule

// File: rtl/sha_w_sched_ctrl.sv
// SHA-256 message schedule controller: round counter, FSM and registered W_t stream.
module sha_w_sched_ctrl
    import sha_w_sched_ctrl_pkg::*;
#(
    parameter int unsigned WORD_S = WORD_S_DEF,
    parameter int unsigned ROUNDS = ROUNDS_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [W_BLKCNT*WORD_S-1:0]   block_in,
    input  logic                         hold,
    input  logic                         abort,
    output logic                         ready,
    output logic                         w_valid,
    output logic [WORD_S-1:0]            w_out,
    output logic [IDX_W-1:0]             round_idx,
    output logic                         first,
    output logic                         last,
    output logic                         done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t            state;
    logic              load;
    logic              shift;
    logic [WORD_S-1:0] w_next;

    // Window enables: capture on accepted start, slide on every advancing RUN cycle
    assign load  = (state == ST_IDLE) && start && !reset;
    assign shift = (state == ST_RUN) && !hold && !abort && !reset;

    sha_w_window #(
        .WORD_S (WORD_S)
    ) u_window (
        .clk    (clk),
        .load   (load),
        .shift  (shift),
        .block  (block_in),
        .w_next (w_next)
    );

    // FSM, round counter and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ready     <= 1'b1;
            w_valid   <= 1'b0;
            w_out     <= '0;
            round_idx <= '0;
            first     <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        ready     <= 1'b0;
                        w_valid   <= 1'b1;
                        first     <= 1'b1;
                        last      <= (LAST_IDX == IDX_W'(0));
                        round_idx <= '0;
                        w_out     <= block_in[W_BLKCNT*WORD_S-1 -: WORD_S];
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        ready     <= 1'b1;
                        w_valid   <= 1'b0;
                        first     <= 1'b0;
                        last      <= 1'b0;
                        round_idx <= '0;
                        w_out     <= '0;
                    end else if (!hold) begin
                        if (round_idx == LAST_IDX) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            w_valid   <= 1'b0;
                            first     <= 1'b0;
                            last      <= 1'b0;
                            round_idx <= '0;
                            w_out     <= '0;
                        end else begin
                            round_idx <= round_idx + IDX_W'(1);
                            first     <= 1'b0;
                            last      <= ((round_idx + IDX_W'(1)) == LAST_IDX);
                            w_out     <= w_next;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    ready     <= 1'b1;
                    w_valid   <= 1'b0;
                    first     <= 1'b0;
                    last      <= 1'b0;
                    round_idx <= '0;
                    w_out     <= '0;
                end
            endcase
        end
    end

endmodule
